// File: rtl/cpu_defines.sv
// Shared definitions for the pipeline control slice.
// Divide FSM state encoding, default latency and reset/flush levels.
`ifndef RstEnable
`define RstEnable 1'b1
`endif
`ifndef FlushEnable
`define FlushEnable 1'b1
`endif

package cpu_defines;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } DivState_t;

   localparam int DIV_CYCLES_DEF = 32;

endpackage

// File: rtl/div_busy_fsm.sv
// Divide occupancy tracker: IDLE -> BUSY (countdown) -> DONE -> IDLE.
// abort wins over everything; hold freezes state and counter.
module div_busy_fsm
   import cpu_defines::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int CNT_W      = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic abort,
   input  logic hold,
   output logic busy,
   output logic done
);

   localparam logic [CNT_W-1:0] LOAD = CNT_W'(DIV_CYCLES - 2);
   // A two-cycle divide has no BUSY phase at all.
   localparam DivState_t START_ST = (DIV_CYCLES > 2) ? BUSY : DONE;

   DivState_t        state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   always_ff @(posedge clk) begin
      if (rst == `RstEnable) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (abort) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else if (!hold) begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state_nx = START_ST;
                  cnt_nx   = LOAD;
               end
            end
            BUSY: begin
               cnt_nx = (cnt == '0) ? '0 : cnt - 1'b1;
               if (cnt <= CNT_W'(1))
                  state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/stall controller producing PC and pipeline register Wr/Flush strobes.
// Define PIPE_CTRL_PERF_EN to add saturating stall performance counters.
module pipe_ctrl
   import cpu_defines::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic [1:0]  ID_RegsReadSel,
   input  logic        EXE_IsLoad,
   input  logic [4:0]  EXE_Dst,
   input  logic        EXE_IsDiv,
   input  logic        EXE_BranchTaken,
   input  logic        MEM_ExcValid,
   input  logic        ICacheStall,
   input  logic        DCacheStall,
   output logic        PC_Wr,
   output logic        ID_Wr,
   output logic        EXE_Wr,
   output logic        MEM_Wr,
   output logic        WB_Wr,
   output logic        ID_Flush,
   output logic        EXE_Flush,
   output logic        MEM_Flush,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0] Perf_LoadUse,
   output logic [31:0] Perf_DivStall,
   output logic [31:0] Perf_CacheStall,
`endif
   output logic        DivBusy
);

   logic div_busy, div_done, div_run;
   logic exc, dstall, div_stall, low;
   logic load_use, redir_pend, pend_nx;

   div_busy_fsm #(
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (EXE_IsDiv & ~MEM_ExcValid & ~DCacheStall),
      .abort (MEM_ExcValid),
      .hold  (DCacheStall & ~MEM_ExcValid),
      .busy  (div_busy),
      .done  (div_done)
   );

   assign div_run   = div_busy & ~div_done;
   assign exc       = MEM_ExcValid;
   assign dstall    = ~exc & DCacheStall;
   assign div_stall = ~exc & ~DCacheStall
                    & (div_run | (~div_busy & EXE_IsDiv));
   assign low       = ~exc & ~DCacheStall & ~div_stall;

   assign load_use = EXE_IsLoad & (EXE_Dst != 5'd0)
                   & ((ID_RegsReadSel[0] & (ID_rs == EXE_Dst))
                    | (ID_RegsReadSel[1] & (ID_rt == EXE_Dst)));

   assign DivBusy = div_busy;

   always_comb begin
      PC_Wr     = 1'b1;
      ID_Wr     = 1'b1;
      EXE_Wr    = 1'b1;
      MEM_Wr    = 1'b1;
      WB_Wr     = 1'b1;
      ID_Flush  = 1'b0;
      EXE_Flush = 1'b0;
      MEM_Flush = 1'b0;
      if (rst == `RstEnable) begin
         PC_Wr     = 1'b0;
         ID_Wr     = 1'b0;
         EXE_Wr    = 1'b0;
         MEM_Wr    = 1'b0;
         WB_Wr     = 1'b0;
         ID_Flush  = `FlushEnable;
         EXE_Flush = `FlushEnable;
         MEM_Flush = `FlushEnable;
      end else if (exc) begin
         ID_Flush  = `FlushEnable;
         EXE_Flush = `FlushEnable;
         MEM_Flush = `FlushEnable;
      end else if (dstall) begin
         PC_Wr  = 1'b0;
         ID_Wr  = 1'b0;
         EXE_Wr = 1'b0;
         MEM_Wr = 1'b0;
         WB_Wr  = 1'b0;
      end else if (div_stall) begin
         PC_Wr     = 1'b0;
         ID_Wr     = 1'b0;
         EXE_Wr    = 1'b0;
         MEM_Flush = `FlushEnable;
      end else begin
         if (load_use) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Flush = `FlushEnable;
         end else if (ICacheStall) begin
            PC_Wr    = 1'b0;
            ID_Flush = `FlushEnable;
         end
         // A redirect can only be taken once the fetch has returned.
         if (EXE_BranchTaken || redir_pend) begin
            ID_Flush = `FlushEnable;
            PC_Wr    = ~ICacheStall;
         end
      end
   end

   always_comb begin
      pend_nx = redir_pend;
      if (exc)
         pend_nx = ICacheStall;
      else if (low)
         pend_nx = ICacheStall & (redir_pend | EXE_BranchTaken);
   end

   always_ff @(posedge clk) begin
      if (rst == `RstEnable)
         redir_pend <= 1'b0;
      else
         redir_pend <= pend_nx;
   end

`ifdef PIPE_CTRL_PERF_EN
   logic lu_act, div_act, cache_act;

   assign lu_act    = ~rst & low & load_use;
   assign div_act   = ~rst & div_stall;
   assign cache_act = ~rst & (dstall | (low & ~load_use & ICacheStall));

   always_ff @(posedge clk) begin
      if (rst == `RstEnable) begin
         Perf_LoadUse    <= '0;
         Perf_DivStall   <= '0;
         Perf_CacheStall <= '0;
      end else begin
         if (lu_act && Perf_LoadUse != '1)
            Perf_LoadUse <= Perf_LoadUse + 1'b1;
         if (div_act && Perf_DivStall != '1)
            Perf_DivStall <= Perf_DivStall + 1'b1;
         if (cache_act && Perf_CacheStall != '1)
            Perf_CacheStall <= Perf_CacheStall + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (DIV_CYCLES = 32).
// Output vector: {PC,ID,EXE,MEM,WB _Wr, ID,EXE,MEM _Flush, DivBusy}.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ID_rs, ID_rt, EXE_Dst;
   logic [1:0] ID_RegsReadSel;
   logic       EXE_IsLoad, EXE_IsDiv, EXE_BranchTaken;
   logic       MEM_ExcValid, ICacheStall, DCacheStall;
   logic       PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr;
   logic       ID_Flush, EXE_Flush, MEM_Flush, DivBusy;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] Perf_LoadUse, Perf_DivStall, Perf_CacheStall;
`endif

   logic [8:0] outs;
   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.DIV_CYCLES(32), .CNT_W(6)) dut (
      .clk             (clk),
      .rst             (rst),
      .ID_rs           (ID_rs),
      .ID_rt           (ID_rt),
      .ID_RegsReadSel  (ID_RegsReadSel),
      .EXE_IsLoad      (EXE_IsLoad),
      .EXE_Dst         (EXE_Dst),
      .EXE_IsDiv       (EXE_IsDiv),
      .EXE_BranchTaken (EXE_BranchTaken),
      .MEM_ExcValid    (MEM_ExcValid),
      .ICacheStall     (ICacheStall),
      .DCacheStall     (DCacheStall),
      .PC_Wr           (PC_Wr),
      .ID_Wr           (ID_Wr),
      .EXE_Wr          (EXE_Wr),
      .MEM_Wr          (MEM_Wr),
      .WB_Wr           (WB_Wr),
      .ID_Flush        (ID_Flush),
      .EXE_Flush       (EXE_Flush),
      .MEM_Flush       (MEM_Flush),
`ifdef PIPE_CTRL_PERF_EN
      .Perf_LoadUse    (Perf_LoadUse),
      .Perf_DivStall   (Perf_DivStall),
      .Perf_CacheStall (Perf_CacheStall),
`endif
      .DivBusy         (DivBusy)
   );

   assign outs = {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr,
                  ID_Flush, EXE_Flush, MEM_Flush, DivBusy};

   task automatic idle_inputs();
      ID_rs           = 5'd0;
      ID_rt           = 5'd0;
      EXE_Dst         = 5'd0;
      ID_RegsReadSel  = 2'b00;
      EXE_IsLoad      = 1'b0;
      EXE_IsDiv       = 1'b0;
      EXE_BranchTaken = 1'b0;
      MEM_ExcValid    = 1'b0;
      ICacheStall     = 1'b0;
      DCacheStall     = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      #1;
      checks++;
      if (outs !== 9'b000001110) begin
         $display("FAIL reset outs=%b expected %b", outs, 9'b000001110);
         fails++;
      end
      checks++;
      if (dut.redir_pend !== 1'b0 || dut.u_div.cnt !== 6'd0) begin
         $display("FAIL reset_state pend=%b cnt=%0d expected 0/0",
                  dut.redir_pend, dut.u_div.cnt);
         fails++;
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (outs !== 9'b111110000) begin
         $display("FAIL after_reset outs=%b expected %b", outs, 9'b111110000);
         fails++;
      end
   endtask

   typedef struct packed {
      logic       ld;
      logic [4:0] dst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [1:0] sel;
      logic       ic;
      logic [8:0] exp;
   } lu_vec_t;

   task automatic test_load_use();
      lu_vec_t v [7];
      v[0] = '{1'b1, 5'd5, 5'd5, 5'd0, 2'b01, 1'b0, 9'b001110100};
      v[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 9'b111110000};
      v[2] = '{1'b1, 5'd7, 5'd0, 5'd7, 2'b10, 1'b0, 9'b001110100};
      v[3] = '{1'b1, 5'd7, 5'd0, 5'd7, 2'b01, 1'b0, 9'b111110000};
      v[4] = '{1'b0, 5'd5, 5'd5, 5'd0, 2'b01, 1'b0, 9'b111110000};
      v[5] = '{1'b1, 5'd5, 5'd5, 5'd0, 2'b01, 1'b1, 9'b001110100};
      v[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 9'b011111000};
      for (int i = 0; i < 7; i++) begin
         tick();
         EXE_IsLoad     = v[i].ld;
         EXE_Dst        = v[i].dst;
         ID_rs          = v[i].rs;
         ID_rt          = v[i].rt;
         ID_RegsReadSel = v[i].sel;
         ICacheStall    = v[i].ic;
         #1;
         checks++;
         if (outs !== v[i].exp) begin
            $display("FAIL load_use vec %0d outs=%b expected %b",
                     i, outs, v[i].exp);
            fails++;
         end
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_divide();
      logic [8:0] exp;
      for (int i = 0; i <= 32; i++) begin
         tick();
         EXE_IsDiv = (i < 32);
         #1;
         if (i == 0)       exp = 9'b000110010;
         else if (i < 31)  exp = 9'b000110011;
         else if (i == 31) exp = 9'b111110001;
         else              exp = 9'b111110000;
         checks++;
         if (outs !== exp) begin
            $display("FAIL divide cyc %0d outs=%b expected %b", i, outs, exp);
            fails++;
         end
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp;
      for (int i = 0; i <= 34; i++) begin
         tick();
         EXE_IsDiv    = (i < 34);
         MEM_ExcValid = (i == 34);
         #1;
         if (i == 31)      exp = 9'b111110001;
         else if (i == 32) exp = 9'b000110010;
         else if (i == 33) exp = 9'b000110011;
         else              exp = 9'b111111111;
         if (i >= 31) begin
            checks++;
            if (outs !== exp) begin
               $display("FAIL back_to_back cyc %0d outs=%b expected %b",
                        i, outs, exp);
               fails++;
            end
         end
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (outs !== 9'b111110000) begin
         $display("FAIL b2b_abort outs=%b expected %b", outs, 9'b111110000);
         fails++;
      end
   endtask

   task automatic test_div_abort();
      for (int i = 0; i < 10; i++) begin
         tick();
         EXE_IsDiv = 1'b1;
      end
      tick();
      MEM_ExcValid = 1'b1;
      #1;
      checks++;
      if (outs !== 9'b111111111) begin
         $display("FAIL div_abort pulse outs=%b expected %b",
                  outs, 9'b111111111);
         fails++;
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (outs !== 9'b111110000) begin
         $display("FAIL div_abort after outs=%b expected %b",
                  outs, 9'b111110000);
         fails++;
      end
   endtask

   task automatic test_branch_imiss();
      for (int i = 0; i < 4; i++) begin
         tick();
         EXE_BranchTaken = (i == 0);
         ICacheStall     = 1'b1;
         #1;
         checks++;
         if (outs !== 9'b011111000 || (i > 0 && dut.redir_pend !== 1'b1)) begin
            $display("FAIL branch_imiss cyc %0d outs=%b pend=%b expected %b/1",
                     i, outs, dut.redir_pend, 9'b011111000);
            fails++;
         end
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (outs !== 9'b111111000) begin
         $display("FAIL branch_release outs=%b expected %b", outs, 9'b111111000);
         fails++;
      end
      tick();
      #1;
      checks++;
      if (outs !== 9'b111110000 || dut.redir_pend !== 1'b0) begin
         $display("FAIL branch_clear outs=%b pend=%b expected %b/0",
                  outs, dut.redir_pend, 9'b111110000);
         fails++;
      end
   endtask

   task automatic test_dcache_freeze();
      for (int i = 0; i <= 35; i++) begin
         tick();
         EXE_IsDiv   = (i < 35);
         DCacheStall = (i >= 24 && i <= 26);
         #1;
         if (i >= 24 && i <= 27) begin
            checks++;
            if (dut.u_div.cnt !== 6'd7) begin
               $display("FAIL dcache cnt cyc %0d cnt=%0d expected 7",
                        i, dut.u_div.cnt);
               fails++;
            end
         end
         if (i >= 24 && i <= 26) begin
            checks++;
            if (outs !== 9'b000000001) begin
               $display("FAIL dcache frozen cyc %0d outs=%b expected %b",
                        i, outs, 9'b000000001);
               fails++;
            end
         end
         if (i == 33 || i == 34 || i == 35) begin
            checks++;
            if (outs !== (i == 33 ? 9'b000110011 :
                          i == 34 ? 9'b111110001 : 9'b111110000)) begin
               $display("FAIL dcache tail cyc %0d outs=%b", i, outs);
               fails++;
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_div();
      tick();
      EXE_BranchTaken = 1'b1;
      ICacheStall     = 1'b1;
      tick();
      EXE_BranchTaken = 1'b0;
      EXE_IsDiv       = 1'b1;
      #1;
      checks++;
      if (outs !== 9'b000110010 || dut.redir_pend !== 1'b1) begin
         $display("FAIL pend_div outs=%b pend=%b expected %b/1",
                  outs, dut.redir_pend, 9'b000110010);
         fails++;
      end
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (outs !== 9'b000001111 || dut.redir_pend !== 1'b1) begin
         $display("FAIL rst_mid_div outs=%b pend=%b expected %b/1",
                  outs, dut.redir_pend, 9'b000001111);
         fails++;
      end
      tick();
      rst = 1'b0;
      idle_inputs();
      #1;
      checks++;
      if (outs !== 9'b111110000 || dut.redir_pend !== 1'b0) begin
         $display("FAIL rst_mid_div after outs=%b pend=%b expected %b/0",
                  outs, dut.redir_pend, 9'b111110000);
         fails++;
      end
   endtask

   task automatic test_exc_dcache();
      tick();
      MEM_ExcValid = 1'b1;
      DCacheStall  = 1'b1;
      ICacheStall  = 1'b1;
      #1;
      checks++;
      if (outs !== 9'b111111110) begin
         $display("FAIL exc_dcache outs=%b expected %b", outs, 9'b111111110);
         fails++;
      end
      tick();
      MEM_ExcValid = 1'b0;
      DCacheStall  = 1'b0;
      #1;
      checks++;
      if (outs !== 9'b011111000 || dut.redir_pend !== 1'b1) begin
         $display("FAIL exc_pend outs=%b pend=%b expected %b/1",
                  outs, dut.redir_pend, 9'b011111000);
         fails++;
      end
      tick();
      ICacheStall = 1'b0;
      #1;
      checks++;
      if (outs !== 9'b111111000) begin
         $display("FAIL exc_release outs=%b expected %b", outs, 9'b111111000);
         fails++;
      end
      tick();
      #1;
      checks++;
      if (outs !== 9'b111110000 || dut.redir_pend !== 1'b0) begin
         $display("FAIL exc_clear outs=%b pend=%b expected %b/0",
                  outs, dut.redir_pend, 9'b111110000);
         fails++;
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_divide();
      test_back_to_back();
      test_div_abort();
      test_branch_imiss();
      test_dcache_freeze();
      test_reset_mid_div();
      test_exc_dcache();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard/stall controller. Generates the write-enable (`*_Wr`) and flush (`*_Flush`) strobes consumed by the PC register and by the ID, EXE, MEM and WB pipeline registers.
- Sits beside the datapath and resolves four hazards: load-use, multi-cycle divide, I-/D-cache miss, and branch/exception redirect.
- Owns a divide-busy FSM and a pending-redirect latch, so that a redirect overlapping an I-cache miss is not lost.

Parameters:
- DIV_CYCLES, 32, EXE-stage cycles a DIV/DIVU occupies before its result is valid (2..63).
- CNT_W, 6, width of the divide counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ID_rs  in  5  rs of instruction in ID
- ID_rt  in  5  rt of instruction in ID
- ID_RegsReadSel  in  2  bit0 = rs read, bit1 = rt read
- EXE_IsLoad  in  1  instruction in EXE is a load
- EXE_Dst  in  5  destination register of EXE instruction
- EXE_IsDiv  in  1  instruction in EXE is DIV/DIVU
- EXE_BranchTaken  in  1  EXE resolved a taken branch/jump (1-cycle pulse)
- MEM_ExcValid  in  1  MEM holds an exception/ERET redirect
- ICacheStall  in  1  fetch not yet returned
- DCacheStall  in  1  MEM access not yet complete
- PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr  out  1 each  register write enables
- ID_Flush, EXE_Flush, MEM_Flush  out  1 each  load a bubble into that register
- DivBusy  out  1  divide FSM not IDLE

Behaviour:
- Flush has priority over Wr inside each register. Outputs are combinational from the inputs plus internal state.
- Internal state: div_state {IDLE, BUSY, DONE}, div_cnt[CNT_W-1:0], redir_pend.
- Reset: div_state=IDLE, div_cnt=0, redir_pend=0. With rst high, all Wr=0 and all Flush=1; outputs are held in that condition for the reset cycle.
- Hazard priority, highest first; apply the first that matches:
  1. MEM_ExcValid: ID_Flush=EXE_Flush=MEM_Flush=1; PC_Wr=WB_Wr=1. Next state: div_state→IDLE, redir_pend←ICacheStall. Exception wins even if DCacheStall is high.
  2. DCacheStall: all Wr=0, no flush (whole pipe frozen). FSM and div_cnt hold.
  3. div_state==BUSY, or (IDLE and EXE_IsDiv): PC_Wr=ID_Wr=EXE_Wr=0; MEM_Flush=1 (bubble downstream); WB_Wr=1.
  4. Load-use, defined as EXE_IsLoad & EXE_Dst≠0 & ((RegsReadSel[0]&ID_rs==EXE_Dst) | (RegsReadSel[1]&ID_rt==EXE_Dst)): PC_Wr=ID_Wr=0, EXE_Flush=1; MEM_Wr=WB_Wr=1.
  5. ICacheStall: PC_Wr=0, ID_Flush=1; other stages advance.
  6. Otherwise all Wr=1, no flush.
- Branch redirect (applies under rules 4–6): EXE_BranchTaken forces ID_Flush=1 (kills the wrong-path fetch; the delay slot is already in ID) and PC_Wr=1.
- redir_pend:
  - Set when EXE_BranchTaken or MEM_ExcValid occurs with ICacheStall high.
  - While set and ICacheStall high, PC_Wr stays 0.
  - On the first cycle ICacheStall is low with redir_pend set: ID_Flush=1, PC_Wr=1, and redir_pend clears.
- Divide FSM:
  - IDLE→BUSY when EXE_IsDiv and no higher-priority rule; div_cnt←DIV_CYCLES-2.
  - BUSY: div_cnt decrements per cycle when not DCacheStall. At div_cnt==0 → DONE.
  - DONE: stall released; EXE_Wr=1 so the divide leaves EXE; → IDLE.
  - If EXE_IsDiv is still high in DONE, it must not restart; the new divide is evaluated in IDLE the following cycle.
  - Total EXE residency: DIV_CYCLES cycles.
  - MEM_ExcValid in any state → IDLE, div_cnt←0.
- Simultaneous load-use and ICacheStall: load-use wins (ID bubble comes from EXE_Flush; ID_Wr=0 holds ID).
- Simultaneous divide and load-use: divide stall wins; the load-use check re-evaluates afterwards.
- DivBusy = (div_state≠IDLE).

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined: adds outputs Perf_LoadUse[31:0], Perf_DivStall[31:0] and Perf_CacheStall[31:0]. Each is a saturating counter, cleared by rst, that increments once per cycle its rule (4, 3, 2|5) is the active stall.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_defines:
  - typedef DivState_t {IDLE, BUSY, DONE}.
  - Constant DIV_CYCLES_DEF=32.
  - Reuse the existing RstEnable/FlushEnable macros.
- Sub-module div_busy_fsm (FSM + counter, I/O: start, abort, hold, busy, done). All hazard logic stays in pipe_ctrl.

Test Plan:
- Load-use: EXE_IsLoad=1, EXE_Dst=5, ID_rs=5, RegsReadSel=01 → one cycle PC_Wr=ID_Wr=0, EXE_Flush=1. Same with EXE_Dst=0 → no stall.
- Divide: EXE_IsDiv=1 at cycle 0, DIV_CYCLES=32 → EXE_Wr=0 and MEM_Flush=1 for cycles 0..30; EXE_Wr=1 and DivBusy=1 at cycle 31; DivBusy=0 at cycle 32.
- Divide aborted: MEM_ExcValid pulses at cycle 10 of a divide → DivBusy=0 next cycle; ID/EXE/MEM_Flush=1 on the pulse cycle.
- Branch during I-miss: EXE_BranchTaken with ICacheStall=1 for 4 cycles → PC_Wr=0 through the miss; first cycle with ICacheStall=0 gives ID_Flush=1, PC_Wr=1; redir_pend then 0.
- D-cache freeze: DCacheStall=1 for 3 cycles mid-divide (div_cnt=7) → all Wr=0, no flushes, div_cnt still 7 afterwards.
- Reset mid-divide: rst=1 during BUSY → next cycle DivBusy=0, redir_pend=0; all Flush=1 while rst is high.
